// File: rtl/shazam_top.sv
`default_nettype none
// ============================================================================
// Module      : shazam_top (with SHAZAM_ANALYZE_SOUNDS analyser model)
// Description : Audio fingerprint front end. Gates ADC samples into the
//               spectral analyser, keeps a sorted list of the strongest
//               magnitude bins per frame and shifts the bin indices out
//               over a write-only SPI link (mode 1, cs active low).
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Behavioural analyser with the same port contract as the production block.
// Bin k of a frame carries the sum of accepted samples 2k and 2k+1, so a
// frame of FFT_LENGTH samples yields FFT_LENGTH/2 ordered bins with one
// magnitude_ready pulse each.
// ----------------------------------------------------------------------------
module SHAZAM_ANALYZE_SOUNDS (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] adc_data,
    input  logic        adc_data_valid,
    output logic [15:0] magnitude,
    output logic        magnitude_ready
);

    logic        r_phase;
    logic [11:0] r_first;

    // Pair up consecutive samples and emit one bin per pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase         <= 1'b0;
            r_first         <= 12'd0;
            magnitude       <= 16'd0;
            magnitude_ready <= 1'b0;
        end else begin
            magnitude_ready <= 1'b0;
            if (adc_data_valid) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_first <= adc_data;
                end else begin
                    magnitude       <= 16'(r_first) + 16'(adc_data);
                    magnitude_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// ----------------------------------------------------------------------------
// Top level datapath
// ----------------------------------------------------------------------------
module shazam_top #(
    parameter int FFT_LENGTH    = 1024,
    parameter int MAXIMAS_COUNT = 10,
    parameter int SCLK_DIV      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] adc_data,
    input  logic        adc_data_valid,
    output logic        mosi,
    output logic        cs,
    output logic        sclk
);

    localparam int              c_TX_BITS  = 16 * MAXIMAS_COUNT;
    localparam int              c_BIT_W    = $clog2(c_TX_BITS);
    localparam int              c_CNT_W    = $clog2(SCLK_DIV);
    localparam logic [8:0]      c_LAST_BIN = 9'(FFT_LENGTH / 2 - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_TX_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'(SCLK_DIV / 2);
    localparam logic [c_CNT_W-1:0] c_HALF_M1  = c_CNT_W'(SCLK_DIV / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_M1   = c_CNT_W'(SCLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ASSERT_CS   = 2'd1,
        S_SHIFT       = 2'd2,
        S_DEASSERT_CS = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // Sample gate and analyser
    // ------------------------------------------------------------------
    logic        w_sample_valid;
    logic [15:0] w_mag;
    logic        w_mag_ready;

    assign w_sample_valid = adc_data_valid & start;

    SHAZAM_ANALYZE_SOUNDS u_analyser (
        .clk             (clk),
        .reset           (reset),
        .adc_data        (adc_data),
        .adc_data_valid  (w_sample_valid),
        .magnitude       (w_mag),
        .magnitude_ready (w_mag_ready)
    );

    // ------------------------------------------------------------------
    // Bin counter and end-of-frame strobe
    // ------------------------------------------------------------------
    logic [8:0] r_bin;
    logic       r_found;   // maximas_found_active

    // Count bins; the last bin of the frame raises the found strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin   <= 9'd0;
            r_found <= 1'b0;
        end else begin
            r_found <= w_mag_ready && (r_bin == c_LAST_BIN);
            if (w_mag_ready) begin
                r_bin <= (r_bin == c_LAST_BIN) ? 9'd0 : r_bin + 9'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Peak tracker: slot 0 holds the strongest bin. An empty slot ranks
    // below any real bin, so zero-magnitude bins still fill the list in
    // ascending order.
    // ------------------------------------------------------------------
    logic [MAXIMAS_COUNT-1:0][8:0]  r_idx;
    logic [MAXIMAS_COUNT-1:0][15:0] r_mag;
    logic [MAXIMAS_COUNT-1:0]       r_full;

    logic [MAXIMAS_COUNT-1:0][8:0]  w_prev_idx;
    logic [MAXIMAS_COUNT-1:0][15:0] w_prev_mag;
    logic [MAXIMAS_COUNT-1:0]       w_prev_full;
    logic [MAXIMAS_COUNT-1:0]       w_gt;
    logic [MAXIMAS_COUNT-1:0]       w_gt_prev;
    logic [MAXIMAS_COUNT-1:0][8:0]  w_nxt_idx;
    logic [MAXIMAS_COUNT-1:0][15:0] w_nxt_mag;
    logic [MAXIMAS_COUNT-1:0]       w_nxt_full;
    logic                           w_insert;

    assign w_insert    = w_mag_ready && (r_bin != 9'd0);
    assign w_prev_idx  = {r_idx[MAXIMAS_COUNT-2:0], 9'd0};
    assign w_prev_mag  = {r_mag[MAXIMAS_COUNT-2:0], 16'd0};
    assign w_prev_full = {r_full[MAXIMAS_COUNT-2:0], 1'b0};
    assign w_gt_prev   = {w_gt[MAXIMAS_COUNT-2:0], 1'b0};

    // Slot ranking: a slot loses to the new bin only when strictly weaker.
    always_comb begin
        w_gt = '0;
        for (int i = 0; i < MAXIMAS_COUNT; i++) begin
            w_gt[i] = !r_full[i] || (w_mag > r_mag[i]);
        end
    end

    // Insertion: slots below the insert point take their upper neighbour.
    always_comb begin
        w_nxt_idx  = r_idx;
        w_nxt_mag  = r_mag;
        w_nxt_full = r_full;
        for (int i = 0; i < MAXIMAS_COUNT; i++) begin
            if (w_gt_prev[i]) begin
                w_nxt_idx[i]  = w_prev_idx[i];
                w_nxt_mag[i]  = w_prev_mag[i];
                w_nxt_full[i] = w_prev_full[i];
            end else if (w_gt[i]) begin
                w_nxt_idx[i]  = r_bin;
                w_nxt_mag[i]  = w_mag;
                w_nxt_full[i] = 1'b1;
            end
        end
    end

    // Tracker state; the end-of-frame strobe clears it for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_mag  <= '0;
            r_full <= '0;
        end else if (r_found) begin
            r_idx  <= '0;
            r_mag  <= '0;
            r_full <= '0;
        end else if (w_insert) begin
            r_idx  <= w_nxt_idx;
            r_mag  <= w_nxt_mag;
            r_full <= w_nxt_full;
        end
    end

    // ------------------------------------------------------------------
    // Transmit buffer and SPI FSM
    // ------------------------------------------------------------------
    tx_state_t               r_state;
    tx_state_t               w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_BIT_W-1:0]      r_bit;
    logic [c_TX_BITS-1:0]    r_shift;
    logic [c_TX_BITS-1:0]    w_load_word;
    logic                    w_load;
    logic                    w_cnt_end;
    logic                    w_half_end;
    logic                    w_cs;
    logic                    w_sclk;
    logic                    w_mosi;

    // Pack the list with slot 0 in the top word so it leaves first.
    always_comb begin
        w_load_word = '0;
        for (int i = 0; i < MAXIMAS_COUNT; i++) begin
            w_load_word[(MAXIMAS_COUNT-1-i)*16 +: 16] = {7'd0, r_idx[i]};
        end
    end

    assign w_load     = r_found && (r_state == S_IDLE);
    assign w_cnt_end  = (r_cnt == c_DIV_M1);
    assign w_half_end = (r_cnt == c_HALF_M1);

    // Next-state and pin decode; a list arriving mid-burst is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cs        = 1'b1;
        w_sclk      = 1'b0;
        w_mosi      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_ASSERT_CS;
                end
            end
            S_ASSERT_CS: begin
                w_cs = 1'b0;
                if (w_half_end) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_cs   = 1'b0;
                w_sclk = (r_cnt < c_HALF);
                w_mosi = r_shift[c_TX_BITS-1];
                if (w_cnt_end && (r_bit == c_LAST_BIT)) begin
                    w_state_nxt = S_DEASSERT_CS;
                end
            end
            S_DEASSERT_CS: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, phase counter, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) || (w_state_nxt != r_state) || w_cnt_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) begin
                r_shift <= w_load_word;
                r_bit   <= '0;
            end else if ((r_state == S_SHIFT) && w_cnt_end) begin
                r_shift <= {r_shift[c_TX_BITS-2:0], 1'b0};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

    // Registered pins so the off-chip signals are glitch free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs   <= 1'b1;
            sclk <= 1'b0;
            mosi <= 1'b0;
        end else begin
            cs   <= w_cs;
            sclk <= w_sclk;
            mosi <= w_mosi;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shazam_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_shazam_top
// Description : Scoreboard bench for shazam_top. The driver pushes the
//               hand-computed index list of each frame; a monitor decodes
//               SPI words on sclk falling edges and pops/compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shazam_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] adc_data;
    logic        adc_data_valid;
    logic        mosi;
    logic        cs;
    logic        sclk;

    always #5 clk = ~clk;

    shazam_top #(
        .FFT_LENGTH    (1024),
        .MAXIMAS_COUNT (10),
        .SCLK_DIV      (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .mosi           (mosi),
        .cs             (cs),
        .sclk           (sclk)
    );

    int total = 0;
    int bad   = 0;

    int          mag [512];
    logic [15:0] q [$];
    int          exp_tab [5][10] = '{
        '{100, 1, 2, 3, 4, 5, 6, 7, 8, 9},
        '{50, 200, 1, 2, 3, 4, 5, 6, 7, 8},
        '{7, 9, 1, 2, 3, 4, 5, 6, 8, 10},
        '{511, 60, 100, 160, 20, 40, 80, 140, 3, 120},
        '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}
    };

    // Monitor state
    int          bursts    = 0;
    int          cs_falls  = 0;
    int          idle_viol = 0;
    int          edges     = 0;
    int          nbits     = 0;
    bit          in_burst  = 1'b0;
    bit          abort     = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [15:0] word      = 16'd0;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_word(input logic [15:0] w);
        logic [15:0] e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL spi_word: got 0x%04h expected none (queue empty)", w);
        end else begin
            e = q.pop_front();
            if (w !== e) begin
                bad++;
                $display("FAIL spi_word: got 0x%04h expected 0x%04h", w, e);
            end
        end
    endtask

    // SPI receiver: samples mosi on sclk falls, frames words with cs.
    always @(negedge clk) begin
        if (reset) begin
            in_burst = 1'b0;
        end else begin
            if (cs && sclk) idle_viol++;
            if (prev_cs && !cs) begin
                in_burst = 1'b1;
                edges    = 0;
                nbits    = 0;
                cs_falls++;
            end
            if (in_burst && !cs && prev_sclk && !sclk) begin
                word = {word[14:0], mosi};
                nbits++;
                edges++;
                if (nbits == 16) begin
                    nbits = 0;
                    if (!abort) check_word(word);
                end
            end
            if (!prev_cs && cs && in_burst) begin
                in_burst = 1'b0;
                if (!abort) begin
                    bursts++;
                    check("burst_fall_edges", edges, 160);
                end
            end
        end
        prev_cs   = cs;
        prev_sclk = sclk;
    end

    task automatic pulse(input int d, input int sp);
        adc_data       = 12'(d);
        adc_data_valid = 1'b1;
        @(negedge clk);
        adc_data_valid = 1'b0;
        repeat (sp - 1) @(negedge clk);
    endtask

    task automatic load_frame(input int f);
        for (int b = 0; b < 512; b++) mag[b] = 0;
        case (f)
            0: mag[100] = 4000;
            1: begin mag[50] = 2000; mag[200] = 800; end
            2: begin mag[7] = 1000; mag[9] = 1000; end
            3: begin
                mag[0]   = 8190; mag[3]   = 100;  mag[20]  = 500;
                mag[40]  = 500;  mag[60]  = 8000; mag[80]  = 300;
                mag[100] = 7000; mag[120] = 100;  mag[140] = 200;
                mag[160] = 600;  mag[180] = 50;   mag[250] = 40;
                mag[511] = 8190;
            end
            default: ;
        endcase
    endtask

    // One frame of 1024 samples; optional burst of gated-out garbage.
    task automatic send_frame(input int sp, input bit gap);
        int m;
        for (int i = 0; i < 1024; i++) begin
            if (gap && i == 300) begin
                start = 1'b0;
                for (int g = 0; g < 50; g++) pulse(4095, sp);
                start = 1'b1;
            end
            m = mag[i >> 1];
            pulse(((i & 1) != 0) ? (m - (m >> 1)) : (m >> 1), sp);
        end
    endtask

    task automatic wait_bursts(input int n, input int budget);
        for (int c = 0; c < budget && bursts < n; c++) @(negedge clk);
        check("burst_count", bursts, n);
    endtask

    initial begin
        int idle_bad;
        int wc;
        reset          = 1'b1;
        start          = 1'b0;
        adc_data       = 12'd0;
        adc_data_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_cs", int'(cs), 1);
        check("reset_sclk", int'(sclk), 0);
        check("reset_mosi", int'(mosi), 0);
        reset = 1'b0;

        idle_bad = 0;
        repeat (4000) begin
            @(negedge clk);
            if (cs !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);

        for (int i = 0; i < 2048; i++) pulse(i & 12'hfff, 3);
        repeat (1000) @(negedge clk);
        check("gate_cs_falls", cs_falls, 0);

        start = 1'b1;
        for (int f = 0; f < 5; f++) begin
            load_frame(f);
            for (int k = 0; k < 10; k++) q.push_back(16'(exp_tab[f][k]));
            send_frame((f == 0) ? 21 : 3, f == 2);
        end
        wait_bursts(5, 5000);
        check("queue_left", q.size(), 0);
        check("sclk_while_cs_high", idle_viol, 0);
        check("cs_falls_after_frames", cs_falls, 5);

        abort = 1'b1;
        load_frame(4);
        send_frame(2, 1'b0);
        wc = 0;
        while (cs !== 1'b0 && wc < 100) begin
            @(negedge clk);
            wc++;
        end
        check("abort_cs_low", int'(cs), 0);
        repeat (200) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_cs_high", int'(cs), 1);
        check("abort_sclk_low", int'(sclk), 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2000) @(negedge clk);
        check("final_bursts", bursts, 5);
        check("final_cs_falls", cs_falls, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
